block_transfer_sequencer: RTL and testbench
===========================================

Name: block_transfer_sequencer

Overview:
Multi-cycle initiator that drives the register file ports to execute ARM LDM/STM block transfers over a 16-bit register list. It walks the list lowest register first and generates word addresses for all four addressing modes (IA/IB/DA/DB). Each transfer uses a req/ready handshake to the data memory. Optional base writeback goes to the register file. It sits between the control unit (start/done) and the register file / data-memory interface.

Parameters:
ADDR_W, 32, memory address and data width
NREGS, 16, register count; list width and A-port width = log2(NREGS)

Ports:
clock  in  1  system clock, all state updates on rising edge
resetN  in  1  synchronous active-low reset
start  in  1  begin transfer; sampled only in IDLE
isLoad  in  1  1=LDM, 0=STM
preIndex  in  1  P bit
up  in  1  U bit
writeBack  in  1  W bit
baseReg  in  4  base register number
regList  in  16  register list, bit i = Ri
A1  out  4  register file read address
RD1  in  32  register file read data (combinational read)
A3  out  4  register file write address
isWrite  out  1  register file write enable
writeData  out  32  register file write data
memReq  out  1  memory request
memWrite  out  1  1=store
memAddr  out  32  word address
memWriteData  out  32  store data
memReadData  in  32  load data, valid with memReady
memReady  in  1  memory accepts/completes current request this cycle
busy  out  1  high in any state but IDLE
done  out  1  one-cycle completion pulse
pcLoaded  out  1  with done: R15 was loaded

Behaviour:
- Reset: clock and reset are synchronous; when resetN=0 at a clock edge, state goes to IDLE and all internal registers clear. All outputs are 0 while in IDLE, including A1, A3, memAddr and data.
- Reset mid-operation aborts immediately. No further memReq or isWrite is issued.
- States: IDLE, READ_BASE, XFER, WRITEBACK, DONE.
- IDLE: when start=1, latch isLoad, P, U, W, baseReg and regList, then go to READ_BASE. start is ignored in every other state.
- READ_BASE (1 cycle): drive A1=baseReg and capture RD1 as base. n = popcount(list).
- Start address:
  - IA: base
  - IB: base+4
  - DA: base-4n+4
  - DB: base-4n
- Writeback value: base+4n if U=1, else base-4n. All arithmetic is modulo 2^32.
- Empty list (n=0): go to DONE. No memory access, no writeback.
- XFER: cur = lowest set bit of the remaining list.
  - memReq=1 and memAddr=curAddr.
  - STM: memWrite=1, A1=cur, memWriteData=RD1.
  - LDM: memWrite=0.
- Outputs hold stable until memReady=1.
- In the cycle memReady=1:
  - LDM additionally drives isWrite=1, A3=cur, writeData=memReadData.
  - Clear bit cur and add 4 to curAddr.
- With memReady tied high, a transfer takes 1 cycle per register.
- After the last register:
  - go to WRITEBACK if W=1, except when isLoad=1 and list[baseReg]=1 (loaded value wins, writeback suppressed);
  - otherwise go to DONE.
- WRITEBACK (1 cycle): isWrite=1, A3=baseReg, writeData=writeback value.
- STM with the base in the list stores the original base value, because writeback happens after all stores.
- DONE (1 cycle): done=1, and pcLoaded=1 if isLoad and list[15]. Then go to IDLE; start is accepted again in the following cycle.
- R15 is otherwise an ordinary list entry.

Decomposition:
- Shared package:
  - state enum encoding;
  - WORD_BYTES=4;
  - REG_PC=15;
  - addressing-mode decode helper for {P,U} to start-offset selection.
- One sub-module, lowest_set_bit_encoder: 16-bit input gives a 4-bit index plus a valid flag.
- popcount is an inline function.

Test Plan:
1. STMIA, W=1, r13=0x1000, list=0x000E, r1..r3=0xA1/0xA2/0xA3, memReady=1 → writes 0xA1@0x1000, 0xA2@0x1004, 0xA3@0x1008; then r13=0x100C; done at cycle 6 after start (cycle 0).
2. LDMDB, W=0, r0=0x2000, list=0x0030, memory returns 0x55, 0x66 → reads 0x1FF8 then 0x1FFC; r4=0x55, r5=0x66; r0 unchanged; no WRITEBACK cycle.
3. LDMIA, W=1, base=r2, list=0x8004 → r2 receives loaded data, no base writeback; pcLoaded=1 with done.
4. STMIB with memReady held low for 3 cycles on the first beat → memReq, memAddr=base+4 and memWriteData held stable for 4 cycles; exactly 2 beats total for a 2-register list.
5. list=0x0000, W=1 → done 2 cycles after start; memReq and isWrite never asserted.
6. resetN=0 during the second XFER beat → next cycle busy=0, memReq=0, isWrite=0; start is then accepted normally.

Source files
------------

// File: rtl/block_transfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_transfer_sequencer_pkg
// Purpose  : Shared constants, state encoding and addressing-mode decode for
//            the LDM/STM block transfer sequencer.
// Contents : S_* state codes, WORD_BYTES, REG_PC, start_ofs_e and
//            start_offset() which maps {P,U} to the start-address rule.
// Revision : 1.0 - initial release
// ============================================================================
package block_transfer_sequencer_pkg;

    // Sequencer state codes
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ_BASE = 3'd1;
    localparam logic [2:0] S_XFER      = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam int WORD_BYTES = 4;
    localparam int REG_PC     = 15;

    // Offset from the base to the lowest transferred word.
    // SPAN is WORD_BYTES times the number of listed registers.
    typedef enum logic [1:0] {
        OFS_ZERO                 = 2'd0,  // IA
        OFS_PLUS_WORD            = 2'd1,  // IB
        OFS_MINUS_SPAN_PLUS_WORD = 2'd2,  // DA
        OFS_MINUS_SPAN           = 2'd3   // DB
    } start_ofs_e;

    function automatic start_ofs_e start_offset(input logic pre, input logic up_dir);
        start_ofs_e ofs;
        case ({pre, up_dir})
            2'b01:   ofs = OFS_ZERO;
            2'b11:   ofs = OFS_PLUS_WORD;
            2'b00:   ofs = OFS_MINUS_SPAN_PLUS_WORD;
            default: ofs = OFS_MINUS_SPAN;
        endcase
        return ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_transfer_sequencer_lowest_set_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_bit_encoder
// Purpose  : Returns the index of the lowest set bit of a vector.
// Ports    : i_vec   - vector to scan
//            o_idx   - index of lowest set bit (0 when none set)
//            o_valid - at least one bit of i_vec is set
// Revision : 1.0 - initial release
// ============================================================================
module lowest_set_bit_encoder
    import block_transfer_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan downwards so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/block_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : block_transfer_sequencer
// Purpose  : Executes ARM LDM/STM block transfers: walks a register list
//            lowest register first, issues one req/ready memory beat per
//            register and optionally writes the updated base back.
// Ports    : clock/resetN           - clock, synchronous active-low reset
//            start/isLoad/preIndex/up/writeBack/baseReg/regList
//                                   - command, latched in IDLE on start
//            A1/RD1                 - register file read port
//            A3/isWrite/writeData   - register file write port
//            memReq/memWrite/memAddr/memWriteData/memReadData/memReady
//                                   - data memory handshake
//            busy/done/pcLoaded     - status to the control unit
// Revision : 1.0 - initial release
// ============================================================================
module block_transfer_sequencer
    import block_transfer_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic              isLoad,
    input  logic              preIndex,
    input  logic              up,
    input  logic              writeBack,
    input  logic [IDX_W-1:0]  baseReg,
    input  logic [NREGS-1:0]  regList,
    output logic [IDX_W-1:0]  A1,
    input  logic [ADDR_W-1:0] RD1,
    output logic [IDX_W-1:0]  A3,
    output logic              isWrite,
    output logic [ADDR_W-1:0] writeData,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [ADDR_W-1:0] memWriteData,
    input  logic [ADDR_W-1:0] memReadData,
    input  logic              memReady,
    output logic              busy,
    output logic              done,
    output logic              pcLoaded
);

    logic [2:0]        r_state;
    logic              r_is_load;
    logic              r_pre;
    logic              r_up;
    logic              r_wb;
    logic [IDX_W-1:0]  r_base_reg;
    logic [NREGS-1:0]  r_list;
    logic [NREGS-1:0]  r_remain;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_wb_value;

    logic [IDX_W:0]    w_count;
    logic [ADDR_W-1:0] w_span;
    logic [ADDR_W-1:0] w_start_addr;
    logic [IDX_W-1:0]  w_cur;
    logic              w_cur_valid;
    logic [NREGS-1:0]  w_remain_next;
    logic              w_wb_needed;

    localparam logic [ADDR_W-1:0] C_WORD = ADDR_W'(WORD_BYTES);

    function automatic logic [IDX_W:0] popcount(input logic [NREGS-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    lowest_set_bit_encoder #(
        .WIDTH (NREGS)
    ) u_lsb (
        .i_vec   (r_remain),
        .o_idx   (w_cur),
        .o_valid (w_cur_valid)
    );

    assign w_count       = popcount(r_list);
    assign w_span        = ADDR_W'(w_count) * C_WORD;
    assign w_remain_next = r_remain & ~(NREGS'(1) << w_cur);
    // A loaded base value takes precedence over the computed writeback.
    assign w_wb_needed   = r_wb && !(r_is_load && r_list[r_base_reg]);

    // RD1 carries the base register during READ_BASE.
    always_comb begin
        w_start_addr = RD1;
        case (start_offset(r_pre, r_up))
            OFS_ZERO:                 w_start_addr = RD1;
            OFS_PLUS_WORD:            w_start_addr = RD1 + C_WORD;
            OFS_MINUS_SPAN_PLUS_WORD: w_start_addr = RD1 - w_span + C_WORD;
            OFS_MINUS_SPAN:           w_start_addr = RD1 - w_span;
            default:                  w_start_addr = RD1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_is_load  <= 1'b0;
            r_pre      <= 1'b0;
            r_up       <= 1'b0;
            r_wb       <= 1'b0;
            r_base_reg <= '0;
            r_list     <= '0;
            r_remain   <= '0;
            r_cur_addr <= '0;
            r_wb_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_load  <= isLoad;
                        r_pre      <= preIndex;
                        r_up       <= up;
                        r_wb       <= writeBack;
                        r_base_reg <= baseReg;
                        r_list     <= regList;
                        r_state    <= S_READ_BASE;
                    end
                end
                S_READ_BASE: begin
                    r_remain   <= r_list;
                    r_cur_addr <= w_start_addr;
                    r_wb_value <= r_up ? (RD1 + w_span) : (RD1 - w_span);
                    r_state    <= (w_count == '0) ? S_DONE : S_XFER;
                end
                S_XFER: begin
                    // An empty remainder cannot stall; it just falls through.
                    if (memReady || !w_cur_valid) begin
                        r_remain   <= w_remain_next;
                        r_cur_addr <= r_cur_addr + C_WORD;
                        if (w_remain_next == '0) begin
                            r_state <= w_wb_needed ? S_WRITEBACK : S_DONE;
                        end
                    end
                end
                S_WRITEBACK: r_state <= S_DONE;
                S_DONE:      r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        A1           = '0;
        A3           = '0;
        isWrite      = 1'b0;
        writeData    = '0;
        memReq       = 1'b0;
        memWrite     = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        done         = 1'b0;
        pcLoaded     = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_READ_BASE: A1 = r_base_reg;
            S_XFER: begin
                memReq  = w_cur_valid;
                memAddr = r_cur_addr;
                if (!r_is_load) begin
                    memWrite     = w_cur_valid;
                    A1           = w_cur;
                    memWriteData = RD1;
                end else if (memReady && w_cur_valid) begin
                    isWrite   = 1'b1;
                    A3        = w_cur;
                    writeData = memReadData;
                end
            end
            S_WRITEBACK: begin
                isWrite   = 1'b1;
                A3        = r_base_reg;
                writeData = r_wb_value;
            end
            S_DONE: begin
                done     = 1'b1;
                pcLoaded = r_is_load && r_list[REG_PC];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_block_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_transfer_sequencer
// Purpose  : Self-checking bench for block_transfer_sequencer: directed
//            vector table, stall and mid-transfer reset sequences, and
//            randomized transfers checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_transfer_sequencer;

    logic        clock = 1'b0;
    logic        resetN, start, isLoad, preIndex, up, writeBack;
    logic [3:0]  baseReg;
    logic [15:0] regList;
    logic [3:0]  A1, A3;
    logic [31:0] RD1, writeData, memAddr, memWriteData, memReadData;
    logic        isWrite, memReq, memWrite, memReady, busy, done, pcLoaded;

    always #5 clock = ~clock;

    block_transfer_sequencer #(.ADDR_W(32), .NREGS(16)) dut (
        .clock(clock), .resetN(resetN), .start(start), .isLoad(isLoad),
        .preIndex(preIndex), .up(up), .writeBack(writeBack),
        .baseReg(baseReg), .regList(regList), .A1(A1), .RD1(RD1),
        .A3(A3), .isWrite(isWrite), .writeData(writeData),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
        .memWriteData(memWriteData), .memReadData(memReadData),
        .memReady(memReady), .busy(busy), .done(done), .pcLoaded(pcLoaded)
    );

    // ---------------- environment: register file and memory ----------------
    logic [31:0] rf [16];
    logic [31:0] rf_init [16];
    logic        rf_load = 1'b0;

    always @(posedge clock) begin
        if (rf_load) rf <= rf_init;
        else if (isWrite) rf[A3] <= writeData;
    end
    assign RD1 = rf[A1];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction
    assign memReadData = mem_fn(memAddr);

    int   ready_mode = 0;      // 0: always ready, 1: random, 2: manual
    logic ready_manual = 1'b1;
    logic rnd_ready = 1'b1;
    always @(posedge clock) rnd_ready <= ($urandom_range(0, 3) != 0);
    assign memReady = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? rnd_ready : ready_manual;

    // ---------------- monitor ----------------
    typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } mem_ev_t;
    typedef struct packed { logic [3:0] idx; logic [31:0] data; } reg_ev_t;

    mem_ev_t mem_log[$];
    reg_ev_t reg_log[$];
    int      cyc = 0;
    int      done_cnt = 0;
    int      done_cyc = 0;
    logic    done_pc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resetN === 1'b1) begin
            if (memReq && memReady)
                mem_log.push_back('{memWrite, memAddr, memWrite ? memWriteData : 32'h0});
            if (isWrite) reg_log.push_back('{A3, writeData});
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                done_pc  = pcLoaded;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- behavioural reference ----------------
    logic [31:0] snap [16];
    logic [31:0] exp_rf [16];
    mem_ev_t     exp_mem[$];
    reg_ev_t     exp_reg[$];

    // The transferred words form one contiguous ascending block; it either
    // begins at (or one word above) the base, or ends at (or one word below) it.
    task automatic build_model(input logic ld, input logic p, input logic u,
                               input logic w, input logic [3:0] b, input logic [15:0] l);
        int          n;
        logic [31:0] base, a;
        n    = $countones(l);
        base = snap[b];
        exp_mem.delete();
        exp_reg.delete();
        if (u) a = p ? base + 32'd4 : base;
        else   a = (p ? base - 32'd4 : base) - 32'(4 * (n - 1));
        for (int i = 0; i < 16; i++) begin
            if (l[i]) begin
                if (ld) begin
                    exp_mem.push_back('{1'b0, a, 32'h0});
                    exp_reg.push_back('{4'(i), mem_fn(a)});
                end else begin
                    exp_mem.push_back('{1'b1, a, snap[i]});
                end
                a = a + 32'd4;
            end
        end
        if (n > 0 && w && !(ld && l[b]))
            exp_reg.push_back('{b, u ? base + 32'(4 * n) : base - 32'(4 * n)});
        exp_rf = snap;
        foreach (exp_reg[k]) exp_rf[exp_reg[k].idx] = exp_reg[k].data;
    endtask

    int mem_base, reg_base, done_base, start_cyc;

    task automatic load_rf();
        rf_load = 1'b1;
        step();
        rf_load = 1'b0;
        snap = rf_init;
    endtask

    task automatic launch(input logic ld, input logic p, input logic u,
                          input logic w, input logic [3:0] b, input logic [15:0] l);
        isLoad = ld; preIndex = p; up = u; writeBack = w; baseReg = b; regList = l;
        mem_base  = mem_log.size();
        reg_base  = reg_log.size();
        done_base = done_cnt;
        start_cyc = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        // Scramble command inputs: the DUT must work from its latched copy.
        isLoad = 1'($urandom); preIndex = 1'($urandom); up = 1'($urandom);
        writeBack = 1'($urandom); baseReg = 4'($urandom); regList = 16'($urandom);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done_cnt != done_base) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic compare_model();
        int nm, nr, bad;
        nm = mem_log.size() - mem_base;
        nr = reg_log.size() - reg_base;
        check("mem_beats", nm, exp_mem.size());
        for (int k = 0; k < nm && k < exp_mem.size(); k++) begin
            check("mem_wr",   32'(mem_log[mem_base + k].wr), 32'(exp_mem[k].wr));
            check("mem_addr", mem_log[mem_base + k].addr,    exp_mem[k].addr);
            check("mem_data", mem_log[mem_base + k].data,    exp_mem[k].data);
        end
        check("reg_writes", nr, exp_reg.size());
        for (int k = 0; k < nr && k < exp_reg.size(); k++) begin
            check("reg_idx",  32'(reg_log[reg_base + k].idx), 32'(exp_reg[k].idx));
            check("reg_data", reg_log[reg_base + k].data,     exp_reg[k].data);
        end
        bad = 0;
        for (int k = 0; k < 16; k++) if (rf[k] !== exp_rf[k]) bad++;
        check("rf_mismatch_count", bad, 0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ld, p, u, w;
        logic [3:0]  base;
        logic [15:0] list;
        logic [31:0] basev;
        logic [31:0] exp_first;
        logic [31:0] exp_final;
        int          exp_lat;
        logic        exp_pc;
    } vec_t;

    vec_t vt[7];

    initial begin
        bit ok;
        resetN = 1'b0; start = 1'b0; isLoad = 1'b0; preIndex = 1'b0; up = 1'b0;
        writeBack = 1'b0; baseReg = '0; regList = '0;

        //          ld    p     u     w     base  list      basev      first      final       lat pc
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h000E, 32'h1000, 32'h1000, 32'h100C,     6, 1'b0}; // STMIA
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0030, 32'h2000, 32'h1FF8, 32'h2000,     4, 1'b0}; // LDMDB
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  16'h8004, 32'h3000, 32'h3000, 32'h8EEF3000, 4, 1'b1}; // LDMIA base+pc
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  16'h0003, 32'h0100, 32'h00FC, 32'h00F8,     5, 1'b0}; // STMDA
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  16'h0000, 32'h0040, 32'h0000, 32'h0040,     2, 1'b0}; // empty
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0101, 32'h0500, 32'h0504, 32'h0508,     5, 1'b0}; // LDMIB
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 16'h2010, 32'h1000, 32'h0FF8, 32'h0FF8,     5, 1'b0}; // STMDB base in list

        for (int k = 0; k < 16; k++) rf_init[k] = 32'hA0 + 32'(k);
        load_rf();
        step();

        // Reset state: everything quiet.
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_memReq",  32'(memReq),  32'd0);
        check("rst_isWrite", 32'(isWrite), 32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_memAddr", memAddr,      32'd0);
        resetN = 1'b1;
        step();
        check("idle_busy",   32'(busy),    32'd0);
        check("idle_A1",     32'(A1),      32'd0);

        // Directed table, memory always ready.
        ready_mode = 0;
        foreach (vt[i]) begin
            for (int k = 0; k < 16; k++) rf_init[k] = 32'hA0 + 32'(k);
            rf_init[vt[i].base] = vt[i].basev;
            load_rf();
            build_model(vt[i].ld, vt[i].p, vt[i].u, vt[i].w, vt[i].base, vt[i].list);
            launch(vt[i].ld, vt[i].p, vt[i].u, vt[i].w, vt[i].base, vt[i].list);
            check("started_busy", 32'(busy), 32'd1);
            wait_done(ok);
            if (!ok) do_reset();
            check("latency", done_cyc - start_cyc, vt[i].exp_lat);
            check("pcLoaded", 32'(done_pc), 32'(vt[i].exp_pc));
            check("back_idle", 32'(busy), 32'd0);
            if (vt[i].list != 16'h0)
                check("first_addr", (mem_log.size() > mem_base) ? mem_log[mem_base].addr : 32'hFFFF_FFFF,
                      vt[i].exp_first);
            else
                check("empty_no_access", mem_log.size() - mem_base + reg_log.size() - reg_base, 0);
            check("final_base", rf[vt[i].base], vt[i].exp_final);
            compare_model();
        end

        // STMIB with three stalled cycles on the first beat.
        for (int k = 0; k < 16; k++) rf_init[k] = 32'hA0 + 32'(k);
        rf_init[6] = 32'h200;
        load_rf();
        ready_mode   = 2;
        ready_manual = 1'b0;
        launch(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0006);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) ready_manual = 1'b1;
            check("stall_req",   32'(memReq),   32'd1);
            check("stall_wr",    32'(memWrite), 32'd1);
            check("stall_addr",  memAddr,       32'h204);
            check("stall_wdata", memWriteData,  32'hA1);
            step();
        end
        check("beat2_addr",  memAddr,      32'h208);
        check("beat2_wdata", memWriteData, 32'hA2);
        wait_done(ok);
        if (!ok) do_reset();
        check("stall_beats",   mem_log.size() - mem_base, 2);
        check("stall_latency", done_cyc - start_cyc, 7);
        ready_mode = 0;

        // Reset during the second beat of an STMIA with writeback.
        for (int k = 0; k < 16; k++) rf_init[k] = 32'hA0 + 32'(k);
        rf_init[13] = 32'h1000;
        load_rf();
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h000F);
        step();
        step();
        check("pre_rst_addr", memAddr, 32'h1004);
        resetN = 1'b0;
        step();
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_memReq",  32'(memReq),  32'd0);
        check("abort_isWrite", 32'(isWrite), 32'd0);
        step();
        resetN = 1'b1;
        step();
        check("abort_no_wb", rf[13], 32'h1000);
        snap = rf_init;
        build_model(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h0006);
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h0006);
        check("restart_busy", 32'(busy), 32'd1);
        wait_done(ok);
        if (!ok) do_reset();
        compare_model();

        // Randomized transfers with random memory stalls.
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            logic        ld, p, u, w;
            logic [3:0]  b;
            logic [15:0] l;
            for (int k = 0; k < 16; k++) rf_init[k] = $urandom;
            ld = 1'($urandom); p = 1'($urandom); u = 1'($urandom); w = 1'($urandom);
            b  = 4'($urandom_range(0, 15));
            l  = 16'($urandom);
            if (t % 7 == 0) l = 16'h0;
            if (t % 5 == 0) l[b] = 1'b1;
            if (t % 4 == 0) rf_init[b] = 32'($urandom_range(0, 7)) * 32'd4;
            load_rf();
            build_model(ld, p, u, w, b, l);
            launch(ld, p, u, w, b, l);
            wait_done(ok);
            if (!ok) do_reset();
            check("rnd_pcLoaded", 32'(done_pc), 32'(ld && l[15]));
            compare_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
